// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the write-back path.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer,
// which moves just past the winner on every grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N-1:0]                          req,
  input  logic                                  en,
  output logic [N-1:0]                          gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  gnt_idx
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] candIdx;
  logic             found;

  // Winner index is computed even when disabled; only the grant vector is gated.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    candIdx = '0;
    for (int k = 0; k < N; k++) begin
      candIdx = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[candIdx]) begin
        found   = 1'b1;
        gnt_idx = candIdx;
      end
    end
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register file write port among NUM_REQ write-back requesters.
// Define REG_WRITE_ARB_STATS_EN to add the stat_drop_cnt (x0 write) counter.
module reg_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = XLEN,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_write,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  output logic                      busy
`ifdef REG_WRITE_ARB_STATS_EN
  ,
  output logic [15:0]               stat_drop_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]  gntIdx;
  logic              grantEn;
  logic              xfer;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic              selIsZero;

  assign grantEn = ~wb_hold & ~reset;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (grantEn),
    .gnt     (req_ready),
    .gnt_idx (gntIdx)
  );

  assign xfer      = |req_ready;
  assign selAddr   = req_addr[gntIdx*ADDR_W +: ADDR_W];
  assign selData   = req_data[gntIdx*DATA_W +: DATA_W];
  assign selIsZero = (selAddr == ADDR_W'(REG_ZERO));
  assign busy      = (|req_valid) | rf_write;

  // x0 writes still load addr/data but never raise the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
    end else if (xfer) begin
      rf_write <= ~selIsZero;
      rf_addr  <= selAddr;
      rf_data  <= selData;
    end else begin
      rf_write <= 1'b0;
    end
  end

`ifdef REG_WRITE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_drop_cnt <= '0;
    end else if (xfer && selIsZero && (stat_drop_cnt != 16'hFFFF)) begin
      stat_drop_cnt <= stat_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter (NUM_REQ=2); expected writes are queued by
// the stimulus and popped by a monitor whenever rf_write is seen.
module tb_reg_write_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_hold = 1'b0;
  logic [1:0]  req_valid = 2'b11;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_data = '0;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        busy;
`ifdef REG_WRITE_ARB_STATS_EN
  logic [15:0] stat_drop_cnt;
`endif

  int checks = 0;
  int failures = 0;
  wr_t expQ[$];

  reg_write_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_hold   (wb_hold),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_write  (rf_write),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .busy      (busy)
`ifdef REG_WRITE_ARB_STATS_EN
    ,
    .stat_drop_cnt (stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus; the granted write (if any, and not to x0) is queued.
  task automatic applyStimulus(input logic rst, input logic hold, input logic [1:0] valid,
                               input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1,
                               input logic [1:0] expReady);
    wr_t w;
    @(posedge clk);
    #1;
    reset     = rst;
    wb_hold   = hold;
    req_valid = valid;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    #3;
    checkOutput("req_ready", {30'd0, req_ready}, {30'd0, expReady});
    if (expReady == 2'b01 && a0 != 5'd0) begin
      w.addr = a0; w.data = d0; expQ.push_back(w);
    end else if (expReady == 2'b10 && a1 != 5'd0) begin
      w.addr = a1; w.data = d1; expQ.push_back(w);
    end
  endtask

  // Monitor: every issued register-file write must match the oldest expected one.
  always @(negedge clk) begin
    if (rf_write === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %h, expected no write at %0t",
                 rf_addr, rf_data, $time);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wr_addr", {27'd0, rf_addr}, {27'd0, e.addr});
        checkOutput("wr_data", rf_data, e.data);
      end
    end
  end

  initial begin
    // Reset held two cycles with both requesters valid
    applyStimulus(1, 0, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2, 2'b00);
    applyStimulus(1, 0, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2, 2'b00);
    checkOutput("reset_rf_write", {31'd0, rf_write}, 32'd0);
    checkOutput("reset_rf_addr", {27'd0, rf_addr}, 32'd0);
    checkOutput("reset_rf_data", rf_data, 32'd0);
`ifdef REG_WRITE_ARB_STATS_EN
    checkOutput("reset_stat", {16'd0, stat_drop_cnt}, 32'd0);
`endif
    applyStimulus(0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);

    // Single write from req0
    applyStimulus(0, 0, 2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 2'b01);
    checkOutput("busy_valid", {31'd0, busy}, 32'd1);
    applyStimulus(0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
    checkOutput("t1_rf_write", {31'd0, rf_write}, 32'd1);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    applyStimulus(0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
    checkOutput("t2_rf_write", {31'd0, rf_write}, 32'd0);
    checkOutput("t2_rf_addr_hold", {27'd0, rf_addr}, 32'd5);
    checkOutput("t2_rf_data_hold", rf_data, 32'hDEAD_BEEF);

    // Pointer now 1: a lone req1 write brings it back to 0
    applyStimulus(0, 0, 2'b10, 5'd0, 32'h0, 5'd9, 32'h0000_0011, 2'b10);

    // Contention for 4 cycles: grants 0,1,0,1 to addresses 3,4,3,4
    applyStimulus(0, 0, 2'b11, 5'd3, 32'hA3, 5'd4, 32'hB4, 2'b01);
    applyStimulus(0, 0, 2'b11, 5'd3, 32'hA3_01, 5'd4, 32'hB4, 2'b10);
    applyStimulus(0, 0, 2'b11, 5'd3, 32'hA3_01, 5'd4, 32'hB4_01, 2'b01);
    checkOutput("b2b_rf_write", {31'd0, rf_write}, 32'd1);
    applyStimulus(0, 0, 2'b11, 5'd3, 32'hA3_02, 5'd4, 32'hB4_01, 2'b10);
    checkOutput("b2b_rf_addr", {27'd0, rf_addr}, 32'd3);

    // x0 write from req1 (pointer is 0, req0 idle): accepted but suppressed
    applyStimulus(0, 0, 2'b10, 5'd0, 32'h0, 5'd0, 32'h7, 2'b10);
    applyStimulus(0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
    checkOutput("x0_rf_write", {31'd0, rf_write}, 32'd0);
    checkOutput("x0_rf_addr", {27'd0, rf_addr}, 32'd0);
    checkOutput("x0_rf_data", rf_data, 32'h7);
`ifdef REG_WRITE_ARB_STATS_EN
    checkOutput("x0_stat", {16'd0, stat_drop_cnt}, 32'd1);
`endif

    // Pointer is 0 again; a write from req0, then hold for 3 cycles
    applyStimulus(0, 0, 2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 2'b01);
    applyStimulus(0, 1, 2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 2'b00);
    checkOutput("hold_pending_write", {31'd0, rf_write}, 32'd1);
    applyStimulus(0, 1, 2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 2'b00);
    checkOutput("hold_no_write", {31'd0, rf_write}, 32'd0);
    applyStimulus(0, 1, 2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 2'b00);
    applyStimulus(0, 0, 2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 2'b01);

    // Pointer is 1: grant req1, then req0 (pointer -> 1), then reset pulse
    applyStimulus(0, 0, 2'b10, 5'd0, 32'h0, 5'd10, 32'hAA, 2'b10);
    applyStimulus(0, 0, 2'b01, 5'd11, 32'hBB, 5'd0, 32'h0, 2'b01);
    applyStimulus(1, 0, 2'b11, 5'd12, 32'hC0, 5'd13, 32'hD0, 2'b00);
    applyStimulus(0, 0, 2'b11, 5'd12, 32'hC0, 5'd13, 32'hD0, 2'b01);
    checkOutput("post_reset_rf_write", {31'd0, rf_write}, 32'd0);
`ifdef REG_WRITE_ARB_STATS_EN
    checkOutput("post_reset_stat", {16'd0, stat_drop_cnt}, 32'd0);
`endif
    applyStimulus(0, 0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
